alu_multiword_sequencer: RTL and testbench
==========================================

// Module: alu_multiword_sequencer
// PURPOSE
//  Drives the n-bit ripple ALU as a multi-cycle engine for WORDS*N-bit operands.
//  Feeds one N-bit word per cycle, LS word first, onto the ALU's a/b/cin/ctrl inputs.
//  Collects f/cout/v/z back, chaining the carry between words.
//  Returns the full-width result and flags C/V/Z with a start/done handshake.
//  Sits between the datapath register file and the ALU instance.
// PARAMETERS
//  N      4  ALU slice width in bits; must match the attached ALU
//  WORDS  4  words per operation; operand width W = N*WORDS, WORDS >= 2
// PORTS
//  clk       in   1    rising-edge clock
//  rst_n     in   1    asynchronous active-low reset
//  start     in   1    request; accepted only in IDLE or DONE
//  op        in   2    00 AND, 01 OR, 10 ADD, 11 SUB (a-b)
//  opa       in   W    operand A, sampled on accepted start
//  opb       in   W    operand B, sampled on accepted start
//  busy      out  1    high in RUN
//  done      out  1    one-cycle pulse in DONE
//  result    out  W    final result, held until next accepted start completes
//  c_flag    out  1    carry out of MS word (SUB: 1 = no borrow); 0 for AND/OR
//  v_flag    out  1    alu_v of MS word for ADD/SUB; 0 for AND/OR
//  z_flag    out  1    1 when all W result bits are 0
//  alu_a     out  N    current A word to ALU
//  alu_b     out  N    current B word to ALU
//  alu_cin   out  1    ALU carry-in
//  alu_ctrl  out  2    ALU op, equal to latched op
//  alu_f     in   N    ALU result word
//  alu_cout  in   1    ALU carry out
//  alu_v     in   1    ALU overflow (valid on MS word only)
//  alu_z     in   1    ALU zero for current word
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE, all outputs and registers 0; alu_ctrl=00.
//  - FSM IDLE -> RUN on start; RUN stays for exactly WORDS cycles (word counter k=0..WORDS-1).
//    RUN -> DONE after k=WORDS-1. DONE -> RUN on start, else DONE -> IDLE.
//  - Accept (IDLE/DONE & start): latch opa, opb, op; set k=0; clear result shift reg and zacc=1.
//  - RUN, per cycle:
//    - alu_a/alu_b = word k of latched operands, taken combinationally from the shift-reg LSW.
//    - alu_cin: k=0 -> 1 for SUB, else 0; k>0 -> registered carry of word k-1 for ADD/SUB, 0 for AND/OR.
//    - Capture at edge: alu_f shifts into result MS end; carry_r<=alu_cout; zacc<=zacc&alu_z.
//    - On k=WORDS-1 also capture v_r<=alu_v.
//  - Outside RUN: alu_a=alu_b=0, alu_cin=0.
//  - DONE: result, flags valid and registered; done=1 for exactly one cycle.
//    Outputs hold through IDLE until a new operation reaches DONE.
//  - Latency: start sampled at edge t -> done high in cycle t+WORDS+1.
//    Back-to-back start in DONE gives one op per WORDS+1 cycles.
//  - start while RUN is ignored (no latch, no effect).
//  - Reset mid-RUN aborts: IDLE, result/flags 0, no done pulse.
//  - All arithmetic is modulo 2^W. ALU is purely combinational, so its response is in the same cycle.
// STRUCTURE
//  - Shared package alu_pkg:
//    - op codes OP_AND/OP_OR/OP_ADD/OP_SUB (2 bits)
//    - FSM state typedef {IDLE,RUN,DONE}
//    - clog2-based counter width helper
//  - One sub-module alu_word_shifter: W-bit register with parallel load and N-bit shift-right.
//    Used 3x: opa, opb and result (result loads at MS end).
//  - FSM, counter and flag registers stay in the top module.
// TESTING (N=4, WORDS=4, W=16)
//  1 ADD 0x00FF+0x0001 -> result 0x0100, C=0 V=0 Z=0; done exactly 5 cycles after start edge.
//  2 ADD 0x7FFF+0x0001 -> 0x8000 V=1 C=0; ADD 0xFFFF+0x0001 -> 0x0000 C=1 Z=1 V=0.
//  3 SUB 0x1234-0x1234 -> 0x0000 Z=1 C=1; SUB 0x0000-0x0001 -> 0xFFFF C=0 V=0.
//  4 AND 0xF0F0&0x0FF0 -> 0x00F0, OR 0x0F00|0x00F0 -> 0x0FF0; C=V=0 and alu_cin=0 every RUN cycle.
//  5 Second start pulse during RUN -> ignored, result unchanged.
//    start held high in DONE -> next op begins, done pulses every 5 cycles.
//  6 rst_n low at RUN k=2 -> immediate IDLE, busy=0, outputs 0, no done.
//    Next ADD 0x0001+0x0001 -> 0x0002.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the multi-word ALU sequencer: op codes, FSM states
// and the word-counter width helper.
package alu_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  function automatic int cntWidth(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/alu_word_shifter.sv
// W-bit register with parallel load and an N-bit right shift that inserts a
// new word at the MS end.
module alu_word_shifter #(
  parameter int N = 4,
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] loadData_i,
  input  logic         shift_i,
  input  logic [N-1:0] shiftIn_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q, data_d;

  // Load has priority so a new operation always starts from a clean register.
  always_comb begin
    data_d = data_q;
    if (load_i) begin
      data_d = loadData_i;
    end else if (shift_i) begin
      data_d = {shiftIn_i, data_q[W-1:N]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/alu_multiword_sequencer.sv
// Runs an N-bit combinational ALU over WORDS cycles, LS word first, to build a
// WORDS*N-bit result with C/V/Z flags behind a start/done handshake.
module alu_multiword_sequencer
  import alu_pkg::*;
#(
  parameter int N     = 4,
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [1:0]           op_i,
  input  logic [N*WORDS-1:0]   opa_i,
  input  logic [N*WORDS-1:0]   opb_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [N*WORDS-1:0]   result_o,
  output logic                 c_flag_o,
  output logic                 v_flag_o,
  output logic                 z_flag_o,
  output logic [N-1:0]         alu_a_o,
  output logic [N-1:0]         alu_b_o,
  output logic                 alu_cin_o,
  output logic [1:0]           alu_ctrl_o,
  input  logic [N-1:0]         alu_f_i,
  input  logic                 alu_cout_i,
  input  logic                 alu_v_i,
  input  logic                 alu_z_i
);

  localparam int W  = N * WORDS;
  localparam int CW = cntWidth(WORDS);
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   wordCnt_q, wordCnt_d;
  logic [1:0]      op_q;
  logic            carry_q, zAcc_q;
  logic [W-1:0]    result_q;
  logic            cFlag_q, vFlag_q, zFlag_q;
  logic [W-1:0]    opaSh, opbSh, resSh;
  logic            accept, running, lastWord, arith;
  logic            unusedBits;

  assign accept   = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign running  = (state_q == ST_RUN);
  assign lastWord = running && (wordCnt_q == LAST);
  assign arith    = op_q[1];

  alu_word_shifter #(.N(N), .W(W)) u_opaShifter (
    .clk(clk), .rst_n(rst_n), .load_i(accept), .loadData_i(opa_i),
    .shift_i(running), .shiftIn_i('0), .q_o(opaSh)
  );

  alu_word_shifter #(.N(N), .W(W)) u_opbShifter (
    .clk(clk), .rst_n(rst_n), .load_i(accept), .loadData_i(opb_i),
    .shift_i(running), .shiftIn_i('0), .q_o(opbSh)
  );

  alu_word_shifter #(.N(N), .W(W)) u_resShifter (
    .clk(clk), .rst_n(rst_n), .load_i(accept), .loadData_i('0),
    .shift_i(running), .shiftIn_i(alu_f_i), .q_o(resSh)
  );

  // Words already shifted out of the LS end carry no further information.
  assign unusedBits = &{1'b0, opaSh[W-1:N], opbSh[W-1:N], resSh[N-1:0]};

  always_comb begin
    state_d   = state_q;
    wordCnt_d = wordCnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d   = ST_RUN;
          wordCnt_d = '0;
        end
      end
      ST_RUN: begin
        if (wordCnt_q == LAST) begin
          state_d = ST_DONE;
        end else begin
          wordCnt_d = wordCnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        if (start_i) begin
          state_d   = ST_RUN;
          wordCnt_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Published result and flags only change on the final word, so they hold
  // steady through the next operation's RUN phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      wordCnt_q <= '0;
      op_q      <= OP_AND;
      carry_q   <= 1'b0;
      zAcc_q    <= 1'b0;
      result_q  <= '0;
      cFlag_q   <= 1'b0;
      vFlag_q   <= 1'b0;
      zFlag_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wordCnt_q <= wordCnt_d;
      if (accept) begin
        op_q    <= op_i;
        carry_q <= 1'b0;
        zAcc_q  <= 1'b1;
      end else if (running) begin
        carry_q <= alu_cout_i;
        zAcc_q  <= zAcc_q & alu_z_i;
      end
      if (lastWord) begin
        result_q <= {alu_f_i, resSh[W-1:N]};
        cFlag_q  <= arith & alu_cout_i;
        vFlag_q  <= arith & alu_v_i;
        zFlag_q  <= zAcc_q & alu_z_i;
      end
    end
  end

  // SUB is a + ~b + 1, so the LS word injects the +1 as carry-in.
  always_comb begin
    alu_cin_o = 1'b0;
    if (running) begin
      if (wordCnt_q == '0) begin
        alu_cin_o = (op_q == OP_SUB);
      end else begin
        alu_cin_o = arith & carry_q;
      end
    end
  end

  assign alu_a_o    = running ? opaSh[N-1:0] : '0;
  assign alu_b_o    = running ? opbSh[N-1:0] : '0;
  assign alu_ctrl_o = op_q;
  assign busy_o     = running;
  assign done_o     = (state_q == ST_DONE);
  assign result_o   = result_q;
  assign c_flag_o   = cFlag_q;
  assign v_flag_o   = vFlag_q;
  assign z_flag_o   = zFlag_q;

endmodule

// File: tb/tb_alu_multiword_sequencer.sv
// Bench for alu_multiword_sequencer: attaches a behavioural 4-bit ALU and checks
// against a full-width arithmetic model.
module tb_alu_multiword_sequencer;
  import alu_pkg::*;

  localparam int N     = 4;
  localparam int WORDS = 4;
  localparam int W     = N * WORDS;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] expRes;
    logic [2:0]  expCvz;
  } vec_t;

  logic         clk, rst_n, start;
  logic [1:0]   opSel;
  logic [W-1:0] opa, opb, result;
  logic         busy, done, cFlag, vFlag, zFlag;
  logic [N-1:0] aluA, aluB, aluF, aluBEff;
  logic         aluCin, aluCout, aluV, aluZ;
  logic [1:0]   aluCtrl;
  logic [N:0]   aluSum;
  int           testCount = 0;
  int           failCount = 0;
  vec_t         vecs[8];

  alu_multiword_sequencer #(.N(N), .WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .op_i(opSel),
    .opa_i(opa), .opb_i(opb), .busy_o(busy), .done_o(done),
    .result_o(result), .c_flag_o(cFlag), .v_flag_o(vFlag), .z_flag_o(zFlag),
    .alu_a_o(aluA), .alu_b_o(aluB), .alu_cin_o(aluCin), .alu_ctrl_o(aluCtrl),
    .alu_f_i(aluF), .alu_cout_i(aluCout), .alu_v_i(aluV), .alu_z_i(aluZ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The attached ripple ALU slice, purely combinational.
  always_comb begin
    aluBEff = (aluCtrl == OP_SUB) ? ~aluB : aluB;
    aluSum  = '0;
    case (aluCtrl)
      OP_AND:  aluSum = {1'b0, aluA & aluB};
      OP_OR:   aluSum = {1'b0, aluA | aluB};
      default: aluSum = {1'b0, aluA} + {1'b0, aluBEff} + {{N{1'b0}}, aluCin};
    endcase
  end
  assign aluF    = aluSum[N-1:0];
  assign aluCout = aluCtrl[1] & aluSum[N];
  assign aluV    = aluCtrl[1] & (aluA[N-1] == aluBEff[N-1]) & (aluF[N-1] != aluA[N-1]);
  assign aluZ    = (aluF == '0);

  task automatic refModel(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                          output logic [15:0] r, output logic [2:0] cvz);
    logic [16:0] s;
    logic        v;
    case (op)
      OP_AND:  s = {1'b0, a & b};
      OP_OR:   s = {1'b0, a | b};
      OP_ADD:  s = {1'b0, a} + {1'b0, b};
      default: s = {1'b0, a} + {1'b0, ~b} + 17'd1;
    endcase
    r = s[15:0];
    if (op == OP_ADD)      v = (a[15] == b[15]) && (r[15] != a[15]);
    else if (op == OP_SUB) v = (a[15] != b[15]) && (r[15] != a[15]);
    else                   v = 1'b0;
    cvz = {op[1] & s[16], v, r == 16'h0000};
  endtask

  // Carry into word k is the carry out of the low k*N bits of the full operation.
  function automatic logic expCin(input logic [1:0] op, input logic [15:0] a,
                                  input logic [15:0] b, input int k);
    logic [31:0] mask, lo;
    if (!op[1]) return 1'b0;
    if (k == 0) return (op == OP_SUB);
    mask = (32'd1 << (k * N)) - 32'd1;
    if (op == OP_ADD) lo = ({16'h0, a} & mask) + ({16'h0, b} & mask);
    else              lo = ({16'h0, a} & mask) + ({16'h0, ~b} & mask) + 32'd1;
    return lo[k * N];
  endfunction

  function automatic logic [3:0] wordOf(input logic [15:0] x, input int k);
    return 4'(x >> (k * N));
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    start = 1'b1;
    opSel = op;
    opa   = a;
    opb   = b;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic runAndCheck(input string name, input logic [1:0] op, input logic [15:0] a,
                             input logic [15:0] b, input logic [15:0] expRes, input logic [2:0] expCvz);
    int doneCyc;
    doneCyc = 0;
    applyStimulus(op, a, b);
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (cyc <= WORDS)
        checkOutput({name, " run word"}, 64'({busy, done, aluCtrl, aluCin, aluA, aluB}),
                    64'({1'b1, 1'b0, op, expCin(op, a, b, cyc - 1), wordOf(a, cyc - 1), wordOf(b, cyc - 1)}));
      if (done) begin
        doneCyc = cyc;
        break;
      end
    end
    checkOutput({name, " latency"}, 64'(doneCyc), 64'(WORDS + 1));
    checkOutput({name, " result"}, 64'(result), 64'(expRes));
    checkOutput({name, " cvz"}, 64'({cFlag, vFlag, zFlag}), 64'(expCvz));
    repeat (2) @(negedge clk);
    checkOutput({name, " hold"}, 64'({done, busy, result}), 64'({2'b00, expRes}));
  endtask

  initial begin
    logic [15:0] ra, rb, rRes;
    logic [2:0]  rCvz;
    logic [1:0]  rOp;
    logic [15:0] doneMask;
    int          doneCyc, doneCnt;
    logic        sawDone;

    vecs[0] = '{"add carry word", OP_ADD, 16'h00FF, 16'h0001, 16'h0100, 3'b000};
    vecs[1] = '{"add overflow",   OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 3'b010};
    vecs[2] = '{"add wrap",       OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 3'b101};
    vecs[3] = '{"sub equal",      OP_SUB, 16'h1234, 16'h1234, 16'h0000, 3'b101};
    vecs[4] = '{"sub borrow",     OP_SUB, 16'h0000, 16'h0001, 16'hFFFF, 3'b000};
    vecs[5] = '{"and",            OP_AND, 16'hF0F0, 16'h0FF0, 16'h00F0, 3'b000};
    vecs[6] = '{"or",             OP_OR,  16'h0F00, 16'h00F0, 16'h0FF0, 3'b000};
    vecs[7] = '{"sub overflow",   OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 3'b110};

    rst_n = 1'b0;
    start = 1'b0;
    opSel = 2'b00;
    opa   = '0;
    opb   = '0;
    #2;
    checkOutput("reset outputs",
                64'({busy, done, result, cFlag, vFlag, zFlag, aluA, aluB, aluCin, aluCtrl}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      runAndCheck(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].expRes, vecs[i].expCvz);

    for (int i = 0; i < 40; i++) begin
      rOp = 2'($urandom_range(0, 3));
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      if (i % 8 == 0) rb = ra;
      refModel(rOp, ra, rb, rRes, rCvz);
      runAndCheck("random", rOp, ra, rb, rRes, rCvz);
    end

    // A start pulse arriving mid-RUN must not latch new operands.
    applyStimulus(OP_ADD, 16'h0001, 16'h0002);
    opSel   = OP_SUB;
    opa     = 16'h5555;
    opb     = 16'h1111;
    doneCyc = 0;
    doneCnt = 0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (cyc == 2) start = 1'b1;
      if (cyc == 3) start = 1'b0;
      if (done) begin
        doneCnt++;
        if (doneCyc == 0) doneCyc = cyc;
        checkOutput("ignore start result", 64'(result), 64'h0003);
      end
    end
    checkOutput("ignore start latency", 64'(doneCyc), 64'(WORDS + 1));
    checkOutput("ignore start done count", 64'(doneCnt), 64'd1);

    // Start held high through DONE chains straight into the next operation.
    @(negedge clk);
    start = 1'b1;
    opSel = OP_ADD;
    opa   = 16'h1111;
    opb   = 16'h2222;
    @(posedge clk);
    #1;
    opSel    = OP_SUB;
    opa      = 16'h0F0F;
    opb      = 16'h0101;
    doneMask = '0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (done) begin
        doneMask[cyc] = 1'b1;
        if (cyc == 5)  checkOutput("back to back first", 64'(result), 64'h3333);
        if (cyc == 10) checkOutput("back to back second", 64'(result), 64'h0E0E);
      end
      if (cyc == 6) start = 1'b0;
    end
    checkOutput("back to back done cycles", 64'(doneMask), 64'h0420);

    // Reset in the middle of RUN aborts without a done pulse.
    applyStimulus(OP_ADD, 16'hAAAA, 16'h1111);
    repeat (3) @(negedge clk);
    checkOutput("abort busy before reset", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort outputs",
                64'({busy, done, result, cFlag, vFlag, zFlag, aluA, aluB, aluCin, aluCtrl}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    sawDone = 1'b0;
    repeat (6) begin
      @(negedge clk);
      sawDone = sawDone | done;
    end
    checkOutput("abort no done", 64'(sawDone), 64'd0);
    runAndCheck("post reset add", OP_ADD, 16'h0001, 16'h0001, 16'h0002, 3'b000);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
